// File: rtl/cp0_coproc.sv
// MIPS coprocessor 0: SR/Cause/EPC/PRId state, interrupt vs. exception
// arbitration for the M stage, and the flush/redirect request to the PC logic.
module cp0_coproc #(
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4D49,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_rd_idx,
  input  logic [4:0]  i_wr_idx,
  input  logic [31:0] i_wr_data,
  input  logic        i_cp0_we,
  input  logic        i_exl_clr,
  input  logic        i_exc_req,
  input  logic [4:0]  i_exc_code,
  input  logic [31:0] i_epc_in,
  input  logic        i_bd_in,
  input  logic [5:0]  i_hw_int,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_epc_out,
  output logic        o_take_exc,
  output logic [31:0] o_handler_pc
);

  localparam logic [4:0] IDX_SR    = 5'd12;
  localparam logic [4:0] IDX_CAUSE = 5'd13;
  localparam logic [4:0] IDX_EPC   = 5'd14;
  localparam logic [4:0] IDX_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_take;
  logic        w_take;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc_aligned;

  // Interrupts look at the live lines, not the sampled IP copy.
  assign w_int_req     = r_ie & ~r_exl & (|(i_hw_int & r_im));
  assign w_exc_take    = i_exc_req & ~r_exl;
  assign w_take        = ~i_reset & (w_int_req | w_exc_take);
  assign w_epc_aligned = i_epc_in & ~32'h0000_0003;

  assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
  assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip <= i_hw_int;
      if (w_take) begin
        // Taking the trap discards any mtc0/eret in the same M-stage slot.
        r_exl      <= 1'b1;
        r_epc      <= w_epc_aligned;
        r_bd       <= i_bd_in;
        r_exc_code <= w_int_req ? 5'd0 : i_exc_code;
      end else begin
        if (i_cp0_we) begin
          case (i_wr_idx)
            IDX_SR: begin
              r_im  <= i_wr_data[15:10];
              r_exl <= i_wr_data[1];
              r_ie  <= i_wr_data[0];
            end
            IDX_EPC: r_epc <= i_wr_data;
            default: ;
          endcase
        end
        if (i_exl_clr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_rd_data = 32'd0;
    case (i_rd_idx)
      IDX_SR:    o_rd_data = w_sr;
      IDX_CAUSE: o_rd_data = w_cause;
      IDX_EPC:   o_rd_data = r_epc;
      IDX_PRID:  o_rd_data = PRID_VALUE;
      default:   o_rd_data = 32'd0;
    endcase
  end

  assign o_epc_out    = r_epc;
  assign o_take_exc   = w_take;
  assign o_handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_coproc.sv
// Scoreboard bench for cp0_coproc: a word-level CP0 model predicts each cycle's
// outputs, a separate monitor pops the predictions and compares against the DUT.
module tb_cp0_coproc;

  localparam logic [31:0] PRID    = 32'h0000_4D49;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  typedef struct {
    logic        rst;
    logic [4:0]  rdIdx;
    logic [4:0]  wrIdx;
    logic [31:0] wrData;
    logic        we;
    logic        eclr;
    logic        excReq;
    logic [4:0]  excCode;
    logic [31:0] epcIn;
    logic        bd;
    logic [5:0]  hw;
  } stim_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] epc;
    logic        take;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  rdIdx;
  logic [4:0]  wrIdx;
  logic [31:0] wrData;
  logic        cp0We;
  logic        exlClr;
  logic        excReq;
  logic [4:0]  excCode;
  logic [31:0] epcIn;
  logic        bdIn;
  logic [5:0]  hwInt;
  logic [31:0] rdData;
  logic [31:0] epcOut;
  logic        takeExc;
  logic [31:0] handlerPc;

  int checks   = 0;
  int failures = 0;
  exp_t expQ[$];

  // Reference model state held as architectural 32-bit register words.
  logic [31:0] mSr;
  logic [31:0] mCause;
  logic [31:0] mEpc;

  cp0_coproc dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rd_idx    (rdIdx),
    .i_wr_idx    (wrIdx),
    .i_wr_data   (wrData),
    .i_cp0_we    (cp0We),
    .i_exl_clr   (exlClr),
    .i_exc_req   (excReq),
    .i_exc_code  (excCode),
    .i_epc_in    (epcIn),
    .i_bd_in     (bdIn),
    .i_hw_int    (hwInt),
    .o_rd_data   (rdData),
    .o_epc_out   (epcOut),
    .o_take_exc  (takeExc),
    .o_handler_pc(handlerPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 1'b0; s.rdIdx = 5'd12; s.wrIdx = 5'd0; s.wrData = 32'd0;
    s.we = 1'b0; s.eclr = 1'b0; s.excReq = 1'b0; s.excCode = 5'd0;
    s.epcIn = 32'd0; s.bd = 1'b0; s.hw = 6'd0;
    return s;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    case (idx)
      5'd12:   return mSr;
      5'd13:   return mCause;
      5'd14:   return mEpc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the predicted outputs, then advance the model.
  task automatic applyStimulus(input stim_t s, input bit record);
    exp_t e;
    bit ie, exl, intReq, excTake, take;
    logic [5:0] im;
    @(posedge clk);
    #1;
    reset = s.rst; rdIdx = s.rdIdx; wrIdx = s.wrIdx; wrData = s.wrData;
    cp0We = s.we; exlClr = s.eclr; excReq = s.excReq; excCode = s.excCode;
    epcIn = s.epcIn; bdIn = s.bd; hwInt = s.hw;

    ie      = mSr[0];
    exl     = mSr[1];
    im      = mSr[15:10];
    intReq  = ie && !exl && ((s.hw & im) != 6'd0);
    excTake = s.excReq && !exl;
    take    = !s.rst && (intReq || excTake);

    e.rd   = modelRead(s.rdIdx);
    e.epc  = mEpc;
    e.take = take;
    if (record) expQ.push_back(e);

    if (s.rst) begin
      mSr = 32'd0; mCause = 32'd0; mEpc = 32'd0;
    end else begin
      mCause = (mCause & ~32'h0000_FC00) | ({26'd0, s.hw} << 10);
      if (take) begin
        mSr    = mSr | 32'h2;
        mEpc   = s.epcIn & ~32'h3;
        mCause = (mCause & 32'h0000_FC00) | ({31'd0, s.bd} << 31)
               | ({27'd0, (intReq ? 5'd0 : s.excCode)} << 2);
      end else begin
        if (s.we && s.wrIdx == 5'd12) mSr = s.wrData & 32'h0000_FC03;
        if (s.we && s.wrIdx == 5'd14) mEpc = s.wrData;
        if (s.eclr) mSr = mSr & ~32'h2;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rd_data", rdData, e.rd);
        checkOutput("epc_out", epcOut, e.epc);
        checkOutput("take_exc", {31'd0, takeExc}, {31'd0, e.take});
        checkOutput("handler_pc", handlerPc, HANDLER);
      end
    end
  end

  initial begin
    stim_t s;
    int k;
    logic [4:0] idxPick [6];
    idxPick[0] = 5'd12; idxPick[1] = 5'd13; idxPick[2] = 5'd14;
    idxPick[3] = 5'd15; idxPick[4] = 5'd7;  idxPick[5] = 5'd0;

    s = idleStim();
    s.rst = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);

    // Reset readback of every architected index plus an unmapped one.
    for (int i = 0; i < 5; i++) begin
      s = idleStim(); s.rdIdx = idxPick[i];
      applyStimulus(s, 1'b1);
    end

    // Interrupt taken on first enabled line.
    s = idleStim(); s.we = 1'b1; s.wrIdx = 5'd12; s.wrData = 32'h0000_0401;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.hw = 6'b000001; s.epcIn = 32'h1234_5677;
    applyStimulus(s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s = idleStim(); s.rdIdx = idxPick[i];
      applyStimulus(s, 1'b1);
    end

    // Address-error exception in a delay slot with no interrupt mask.
    s = idleStim(); s.we = 1'b1; s.wrIdx = 5'd12; s.wrData = 32'h0000_0001;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.excReq = 1'b1; s.excCode = 5'd4; s.epcIn = 32'h3008; s.bd = 1'b1;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.rdIdx = 5'd13;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.rdIdx = 5'd14;
    applyStimulus(s, 1'b1);

    // EXL blocks nesting, eret re-opens the window.
    s = idleStim(); s.we = 1'b1; s.wrIdx = 5'd12; s.wrData = 32'h0000_FC03;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.hw = 6'h3F; s.excReq = 1'b1; s.excCode = 5'd12; s.epcIn = 32'h5550;
    applyStimulus(s, 1'b1);
    s.eclr = 1'b1; s.excReq = 1'b0;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.hw = 6'h3F; s.epcIn = 32'h6664;
    applyStimulus(s, 1'b1);

    // Trap wins over a same-cycle EPC write.
    s = idleStim(); s.eclr = 1'b1;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.hw = 6'h01; s.we = 1'b1; s.wrIdx = 5'd14;
    s.wrData = 32'hDEAD_BEEF; s.epcIn = 32'h0000_7000; s.rdIdx = 5'd14;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.rdIdx = 5'd14;
    applyStimulus(s, 1'b1);

    // eret after mtc0 to SR in the same cycle; Cause is not writable.
    s = idleStim(); s.we = 1'b1; s.wrIdx = 5'd12; s.wrData = 32'h0000_0403; s.eclr = 1'b1;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.rdIdx = 5'd12;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.we = 1'b1; s.wrIdx = 5'd13; s.wrData = 32'hFFFF_FFFF; s.rdIdx = 5'd13;
    applyStimulus(s, 1'b1);
    s = idleStim(); s.rdIdx = 5'd13;
    applyStimulus(s, 1'b1);

    // Randomised traffic including occasional mid-run reset.
    for (int n = 0; n < 600; n++) begin
      s = idleStim();
      s.rst     = ($urandom_range(0, 99) < 2);
      k         = $urandom_range(0, 6);
      s.rdIdx   = (k == 6) ? 5'($urandom) : idxPick[k];
      k         = $urandom_range(0, 6);
      s.wrIdx   = (k == 6) ? 5'($urandom) : idxPick[k];
      s.we      = ($urandom_range(0, 99) < 30);
      s.wrData  = $urandom;
      s.eclr    = ($urandom_range(0, 99) < 12);
      s.excReq  = ($urandom_range(0, 99) < 15);
      s.excCode = 5'($urandom);
      s.epcIn   = $urandom;
      s.bd      = 1'($urandom);
      s.hw      = ($urandom_range(0, 99) < 65) ? 6'd0 : 6'($urandom);
      applyStimulus(s, 1'b1);
    end

    for (int t = 0; t < 10 && expQ.size() > 0; t++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
